// File: rtl/mux_lanes_param_pkg.sv
// Shared definitions for the lane merger: output mode encodings and a
// constant log2 helper used to size pointers and lane indices.
package mux_lanes_param_pkg;

    typedef enum logic {
        MODE_TDM     = 1'b0,
        MODE_COMPACT = 1'b1
    } mode_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_lanes_param_if.sv
// Lane-source / serial-sink bundle: parallel frame in, one serial word out.
interface mux_lanes_param_if #(
    parameter int NUM_LANES = 4,
    parameter int DATA_W    = 8
);
    localparam int LANE_W = $clog2(NUM_LANES);

    logic                          mode;
    logic                          in_strobe;
    logic [NUM_LANES-1:0]          valid_in;
    logic [NUM_LANES*DATA_W-1:0]   data_in;
    logic                          in_ready;
    logic [DATA_W-1:0]             data_out;
    logic                          valid_out;
    logic [LANE_W-1:0]             lane_out;
    logic                          err_drop;

    modport master (
        output mode, in_strobe, valid_in, data_in,
        input  in_ready, data_out, valid_out, lane_out, err_drop
    );

    modport slave (
        input  mode, in_strobe, valid_in, data_in,
        output in_ready, data_out, valid_out, lane_out, err_drop
    );

endinterface

// File: rtl/mux_lanes_param_lane_fifo.sv
// Per-lane word FIFO with occupancy count; dout shows the head word.
// Latency: a pushed word is poppable the cycle after the push.
// Backpressure: pushes while full and pops while empty are ignored.
module mux_lanes_param_lane_fifo
    import mux_lanes_param_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [DATA_W-1:0]         din,
    input  logic                      pop,
    output logic [DATA_W-1:0]         dout,
    output logic                      empty,
    output logic                      full,
    output logic [clog2(DEPTH):0]     count
);
    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic              do_push;
    logic              do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_W'(DEPTH));
    assign count   = cnt;
    assign dout    = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mux_lanes_param.sv
// Merges NUM_LANES buffered byte lanes into one serial stream (fixed TDM or compact round-robin).
// Latency: registered output, pop to data_out is 1 cycle; push to data_out is at least 2.
// Backpressure: in_ready low when any lane FIFO is full; frames offered then are dropped and flagged.
module mux_lanes_param
    import mux_lanes_param_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4
) (
    input  logic             clk_4f,
    input  logic             reset,
    mux_lanes_param_if.slave bus
);
    localparam int LANE_W = clog2(NUM_LANES);
    localparam int CNT_W  = clog2(DEPTH) + 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

    logic [DATA_W-1:0]    fifo_dout  [NUM_LANES];
    logic [CNT_W-1:0]     fifo_count [NUM_LANES];
    logic [NUM_LANES-1:0] fifo_empty;
    logic [NUM_LANES-1:0] fifo_full;
    logic [NUM_LANES-1:0] lane_ok;
    logic [NUM_LANES-1:0] push;
    logic [NUM_LANES-1:0] pop;

    logic [LANE_W-1:0]    slot;
    logic [LANE_W-1:0]    rr;
    mode_e                mode_q;
    logic                 in_ready;
    logic                 accept;
    logic                 sel_hit;
    logic [LANE_W-1:0]    sel_lane;
    logic [LANE_W-1:0]    cand;

    logic [DATA_W-1:0]    data_q;
    logic                 valid_q;
    logic [LANE_W-1:0]    lane_q;
    logic                 err_q;

    // Occupancy comes from registered counts, so a full lane popping this
    // cycle still holds off the source until the count actually drops.
    assign in_ready = &lane_ok;
    assign accept   = bus.in_strobe && in_ready;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign lane_ok[i] = (fifo_count[i] < CNT_W'(DEPTH));
        assign push[i]    = accept && bus.valid_in[i] && !fifo_full[i];
        assign pop[i]     = sel_hit && (sel_lane == LANE_W'(i));

        mux_lanes_param_lane_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk   (clk_4f),
            .rst   (reset),
            .push  (push[i]),
            .din   (bus.data_in[i*DATA_W +: DATA_W]),
            .pop   (pop[i]),
            .dout  (fifo_dout[i]),
            .empty (fifo_empty[i]),
            .full  (fifo_full[i]),
            .count (fifo_count[i])
        );
    end

    // Compact search walks from the farthest candidate back to rr so the
    // nearest non-empty lane overwrites earlier hits.
    always_comb begin
        sel_lane = slot;
        sel_hit  = 1'b0;
        cand     = '0;
        if (mode_q == MODE_TDM) begin
            sel_hit = !fifo_empty[slot];
        end else begin
            for (int i = NUM_LANES - 1; i >= 0; i--) begin
                cand = LANE_W'((int'(rr) + i) % NUM_LANES);
                if (!fifo_empty[cand]) begin
                    sel_hit  = 1'b1;
                    sel_lane = cand;
                end
            end
        end
    end

    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            slot    <= '0;
            rr      <= '0;
            mode_q  <= MODE_TDM;
            data_q  <= '0;
            valid_q <= 1'b0;
            lane_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            slot <= (slot == LAST_LANE) ? '0 : slot + 1'b1;
            if (slot == LAST_LANE) mode_q <= mode_e'(bus.mode);

            if (sel_hit) begin
                valid_q <= 1'b1;
                data_q  <= fifo_dout[sel_lane];
                lane_q  <= sel_lane;
            end else begin
                valid_q <= 1'b0;
                data_q  <= '0;
                if (mode_q == MODE_TDM) lane_q <= slot;
            end

            if (mode_q == MODE_COMPACT && sel_hit)
                rr <= (sel_lane == LAST_LANE) ? '0 : sel_lane + 1'b1;

            if (bus.in_strobe && !in_ready) err_q <= 1'b1;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;
    assign bus.lane_out  = lane_q;
    assign bus.err_drop  = err_q;

endmodule

// File: tb/tb_mux_lanes_param.sv
// Directed bench for mux_lanes_param with NUM_LANES=4, DATA_W=8, DEPTH=4.
module tb_mux_lanes_param;

    logic clk_4f;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   tb_cyc;

    mux_lanes_param_if #(.NUM_LANES(4), .DATA_W(8)) bus ();

    mux_lanes_param #(
        .NUM_LANES (4),
        .DATA_W    (8),
        .DEPTH     (4)
    ) dut (
        .clk_4f (clk_4f),
        .reset  (reset),
        .bus    (bus)
    );

    initial clk_4f = 1'b0;
    always #5 clk_4f = ~clk_4f;

    // Edges seen since reset release; slot of the current cycle is tb_cyc % 4.
    always @(posedge clk_4f or posedge reset) begin
        if (reset) tb_cyc <= 0;
        else       tb_cyc <= tb_cyc + 1;
    end

    task automatic step();
        @(posedge clk_4f);
        #1;
    endtask

    task automatic wait_slot(input int s);
        for (int k = 0; k < 4; k++) begin
            step();
            if ((tb_cyc % 4) == s) break;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        n_checks++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.valid_out); end
        n_checks++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", bus.data_out); end
        n_checks++; if (bus.lane_out !== 2'd0) begin n_fail++; $display("FAIL reset_lane: got %0d want 0", bus.lane_out); end
        n_checks++; if (bus.err_drop !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.err_drop); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.in_ready); end
        @(posedge clk_4f);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_tdm_full();
        logic [10:0] exp;
        wait_slot(3);
        bus.in_strobe = 1'b1; bus.valid_in = 4'b1111; bus.data_in = 32'h44332211;
        step();
        bus.in_strobe = 1'b0; bus.valid_in = 4'b0000;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL tdm_full_ready: got %b want 1", bus.in_ready); end
        for (int i = 0; i < 5; i++) begin
            step();
            exp = (i < 4) ? {1'b1, 8'(8'h11 * (i + 1)), 2'(i)} : 11'h000;
            n_checks++;
            if ({bus.valid_out, bus.data_out, bus.lane_out} !== exp) begin
                n_fail++;
                $display("FAIL tdm_full[%0d]: got v/d/l %h want %h", i, {bus.valid_out, bus.data_out, bus.lane_out}, exp);
            end
        end
    endtask

    task automatic test_tdm_sparse();
        logic [10:0] exp;
        wait_slot(3);
        bus.in_strobe = 1'b1; bus.valid_in = 4'b0101; bus.data_in = 32'hE3A2E1A0;
        step();
        bus.in_strobe = 1'b0; bus.valid_in = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            step();
            case (i)
                0:       exp = {1'b1, 8'hA0, 2'd0};
                2:       exp = {1'b1, 8'hA2, 2'd2};
                default: exp = {1'b0, 8'h00, 2'(i % 4)};
            endcase
            n_checks++;
            if ({bus.valid_out, bus.data_out, bus.lane_out} !== exp) begin
                n_fail++;
                $display("FAIL tdm_sparse[%0d]: got v/d/l %h want %h", i, {bus.valid_out, bus.data_out, bus.lane_out}, exp);
            end
        end
    endtask

    task automatic test_compact();
        logic [10:0] exp;
        bus.mode = 1'b1;
        wait_slot(0);
        bus.in_strobe = 1'b1; bus.valid_in = 4'b0101; bus.data_in = 32'hE3A2E1A0;
        step();
        bus.in_strobe = 1'b0; bus.valid_in = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            step();
            case (i)
                0:       exp = {1'b1, 8'hA0, 2'd0};
                1:       exp = {1'b1, 8'hA2, 2'd2};
                default: exp = {1'b0, 8'h00, 2'd2};
            endcase
            n_checks++;
            if ({bus.valid_out, bus.data_out, bus.lane_out} !== exp) begin
                n_fail++;
                $display("FAIL compact[%0d]: got v/d/l %h want %h", i, {bus.valid_out, bus.data_out, bus.lane_out}, exp);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] got[$];
        bus.mode = 1'b0;
        wait_slot(0);
        for (int k = 1; k <= 4; k++) begin
            bus.in_strobe = 1'b1; bus.valid_in = 4'b0001; bus.data_in = 32'(k);
            if (k == 4) begin
                n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_3: got %b want 1", bus.in_ready); end
            end
            step();
        end
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full: got %b want 0", bus.in_ready); end
        n_checks++; if (bus.err_drop !== 1'b0) begin n_fail++; $display("FAIL bp_err_before: got %b want 0", bus.err_drop); end
        bus.data_in = 32'h05;
        step();
        bus.in_strobe = 1'b0; bus.valid_in = 4'b0000;
        n_checks++; if (bus.err_drop !== 1'b1) begin n_fail++; $display("FAIL bp_err_after: got %b want 1", bus.err_drop); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_pop: got %b want 1", bus.in_ready); end
        n_checks++;
        if ({bus.valid_out, bus.data_out, bus.lane_out} !== {1'b1, 8'h01, 2'd0}) begin
            n_fail++;
            $display("FAIL bp_first: got v/d/l %h want %h", {bus.valid_out, bus.data_out, bus.lane_out}, {1'b1, 8'h01, 2'd0});
        end
        for (int i = 0; i < 16; i++) begin
            step();
            if (bus.valid_out === 1'b1) begin
                got.push_back(bus.data_out);
                n_checks++; if (bus.lane_out !== 2'd0) begin n_fail++; $display("FAIL bp_lane: got %0d want 0", bus.lane_out); end
            end
        end
        n_checks++; if (got.size() != 3) begin n_fail++; $display("FAIL bp_count: got %0d further words want 3", got.size()); end
        for (int i = 0; i < got.size() && i < 3; i++) begin
            n_checks++;
            if (got[i] !== 8'(i + 2)) begin n_fail++; $display("FAIL bp_word[%0d]: got %h want %h", i, got[i], 8'(i + 2)); end
        end
        err_persist_check: begin
            n_checks++; if (bus.err_drop !== 1'b1) begin n_fail++; $display("FAIL bp_err_sticky: got %b want 1", bus.err_drop); end
        end
    endtask

    task automatic test_mode_switch();
        logic [10:0] exp;
        wait_slot(1);
        bus.in_strobe = 1'b1; bus.valid_in = 4'b0100; bus.data_in = 32'h00C20000;
        step();
        bus.mode = 1'b1;
        bus.valid_in = 4'b0010; bus.data_in = 32'h0000B100;
        step();
        bus.in_strobe = 1'b0; bus.valid_in = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            case (i)
                0:       exp = {1'b1, 8'hC2, 2'd2};
                1:       exp = {1'b0, 8'h00, 2'd3};
                2:       exp = {1'b1, 8'hB1, 2'd1};
                default: exp = {1'b0, 8'h00, 2'd1};
            endcase
            n_checks++;
            if ({bus.valid_out, bus.data_out, bus.lane_out} !== exp) begin
                n_fail++;
                $display("FAIL mode_switch[%0d]: got v/d/l %h want %h", i, {bus.valid_out, bus.data_out, bus.lane_out}, exp);
            end
        end
    endtask

    task automatic test_async_reset();
        bus.mode = 1'b0;
        wait_slot(3);
        bus.in_strobe = 1'b1; bus.valid_in = 4'b1111; bus.data_in = 32'hD3D2D1D0;
        step();
        bus.in_strobe = 1'b0; bus.valid_in = 4'b0000;
        step();
        n_checks++;
        if ({bus.valid_out, bus.data_out, bus.lane_out} !== {1'b1, 8'hD0, 2'd0}) begin
            n_fail++;
            $display("FAIL arst_pre: got v/d/l %h want %h", {bus.valid_out, bus.data_out, bus.lane_out}, {1'b1, 8'hD0, 2'd0});
        end
        #3;
        reset = 1'b1;
        #1;
        n_checks++; if (bus.valid_out !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b want 0", bus.valid_out); end
        n_checks++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL arst_data: got %h want 00", bus.data_out); end
        n_checks++; if (bus.lane_out !== 2'd0) begin n_fail++; $display("FAIL arst_lane: got %0d want 0", bus.lane_out); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_ready: got %b want 1", bus.in_ready); end
        n_checks++; if (bus.err_drop !== 1'b0) begin n_fail++; $display("FAIL arst_err: got %b want 0", bus.err_drop); end
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            n_checks++;
            if (bus.valid_out !== 1'b0 || bus.data_out !== 8'h00) begin
                n_fail++;
                $display("FAIL arst_stale[%0d]: got valid %b data %h want 0/00", i, bus.valid_out, bus.data_out);
            end
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b1;
        bus.mode      = 1'b0;
        bus.in_strobe = 1'b0;
        bus.valid_in  = '0;
        bus.data_in   = '0;
        test_reset();
        test_tdm_full();
        test_tdm_sparse();
        test_compact();
        test_backpressure();
        test_mode_switch();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded 100000 time units");
        $fatal(1);
    end

endmodule
